// File: rtl/psram_line_buffer.sv
// Single-line read buffer with write-through to a PSRAM burst controller.
// A read miss refills the whole aligned line with one burst; writes go straight through.
module psram_line_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [31:0]           d,
    input  logic                  rd,
    input  logic                  we,
    input  logic                  flush,
    output logic [31:0]           spo,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_d,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic                  mem_burst_en,
    output logic [7:0]            mem_burst_length,
    input  logic [31:0]           mem_spo,
    input  logic                  mem_ready
);

    // state    | meaning
    // INIT     | wait for the controller to come up after reset
    // IDLE     | accept rd / we / flush; read hits are served here
    // FILL_REQ | issue the line burst read once the controller is ready
    // FILL     | collect one word per mem_ready rise
    // WR_REQ   | issue the single-word write once the controller is ready
    // WR_WAIT  | wait for the write completion rise

    localparam int LW_BITS = $clog2(LINE_WORDS);
    localparam int CNT_W   = LW_BITS + 1;
    localparam int TAG_W   = ADDR_WIDTH - 2 - LW_BITS;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_FILL_REQ, S_FILL, S_WR_REQ, S_WR_WAIT
    } state_t;

    state_t state_q, state_d;

    logic                  ready_q, ready_d;
    logic [31:0]           spo_q, spo_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_burst_en_q, mem_burst_en_d;
    logic [7:0]            mem_burst_length_q, mem_burst_length_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [31:0]           mem_d_q, mem_d_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [31:0]           d_q, d_d;
    logic [31:0]           line_q [LINE_WORDS];
    logic [31:0]           line_d [LINE_WORDS];

    logic [LW_BITS-1:0] a_word, q_word;
    logic [TAG_W-1:0]   a_tag, q_tag;
    logic               rise, idle_go, valid_eff, rd_hit, wr_hit, fill_last;

    assign a_word    = a[LW_BITS+1:2];
    assign a_tag     = a[ADDR_WIDTH-1:LW_BITS+2];
    assign q_word    = a_q[LW_BITS+1:2];
    assign q_tag     = a_q[ADDR_WIDTH-1:LW_BITS+2];
    assign rise      = mem_ready & ~mem_ready_q;
    assign idle_go   = (state_q == S_IDLE) && ready_q;
    // A flush in the same cycle as a read invalidates first, so the read misses.
    assign valid_eff = valid_q & ~(idle_go & flush);
    assign rd_hit    = valid_eff && (tag_q == a_tag);
    assign wr_hit    = valid_q && (tag_q == q_tag);
    assign fill_last = (state_q == S_FILL) && rise && (cnt_q == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:     if (mem_ready) state_d = S_IDLE;
            S_IDLE: begin
                if (ready_q) begin
                    if (we)                 state_d = S_WR_REQ;
                    else if (rd && !rd_hit) state_d = S_FILL_REQ;
                end
            end
            S_FILL_REQ: if (mem_ready) state_d = S_FILL;
            S_FILL:     if (fill_last) state_d = S_IDLE;
            S_WR_REQ:   if (mem_ready) state_d = S_WR_WAIT;
            S_WR_WAIT:  if (rise)      state_d = S_IDLE;
            default:    state_d = S_INIT;
        endcase
    end

    always_comb begin
        ready_d            = ready_q;
        spo_d              = spo_q;
        mem_rd_d           = 1'b0;
        mem_we_d           = 1'b0;
        mem_burst_en_d     = mem_burst_en_q;
        mem_burst_length_d = mem_burst_length_q;
        mem_a_d            = mem_a_q;
        mem_d_d            = mem_d_q;
        mem_ready_d        = mem_ready;
        valid_d            = valid_q;
        tag_d              = tag_q;
        cnt_d              = cnt_q;
        a_d                = a_q;
        d_d                = d_q;
        line_d             = line_q;
        case (state_q)
            S_INIT: if (mem_ready) ready_d = 1'b1;
            S_IDLE: begin
                if (ready_q) begin
                    if (flush) valid_d = 1'b0;
                    if (we) begin
                        a_d     = a;
                        d_d     = d;
                        ready_d = 1'b0;
                    end else if (rd) begin
                        if (rd_hit) begin
                            spo_d = line_q[a_word];
                        end else begin
                            a_d     = a;
                            ready_d = 1'b0;
                        end
                    end
                end
            end
            S_FILL_REQ: begin
                if (mem_ready) begin
                    mem_rd_d           = 1'b1;
                    mem_a_d            = {q_tag, {(LW_BITS + 2){1'b0}}};
                    mem_burst_en_d     = 1'b1;
                    mem_burst_length_d = 8'(LINE_WORDS);
                    cnt_d              = '0;
                    valid_d            = 1'b0;
                end
            end
            S_FILL: begin
                if (rise) begin
                    line_d[cnt_q[LW_BITS-1:0]] = mem_spo;
                    cnt_d = cnt_q + 1'b1;
                    if (fill_last) begin
                        tag_d   = q_tag;
                        valid_d = 1'b1;
                        ready_d = 1'b1;
                        // The requested word may be the one arriving right now.
                        if (q_word == cnt_q[LW_BITS-1:0]) spo_d = mem_spo;
                        else                              spo_d = line_q[q_word];
                    end
                end
            end
            S_WR_REQ: begin
                if (mem_ready) begin
                    mem_we_d           = 1'b1;
                    mem_a_d            = a_q;
                    mem_d_d            = d_q;
                    mem_burst_en_d     = 1'b0;
                    mem_burst_length_d = 8'd0;
                    if (wr_hit) line_d[q_word] = d_q;
                end
            end
            S_WR_WAIT: if (rise) ready_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q            <= 1'b0;
            spo_q              <= '0;
            mem_rd_q           <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_burst_en_q     <= 1'b0;
            mem_burst_length_q <= '0;
            mem_a_q            <= '0;
            mem_d_q            <= '0;
            mem_ready_q        <= 1'b0;
            valid_q            <= 1'b0;
            tag_q              <= '0;
            cnt_q              <= '0;
            a_q                <= '0;
            d_q                <= '0;
        end else begin
            ready_q            <= ready_d;
            spo_q              <= spo_d;
            mem_rd_q           <= mem_rd_d;
            mem_we_q           <= mem_we_d;
            mem_burst_en_q     <= mem_burst_en_d;
            mem_burst_length_q <= mem_burst_length_d;
            mem_a_q            <= mem_a_d;
            mem_d_q            <= mem_d_d;
            mem_ready_q        <= mem_ready_d;
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            cnt_q              <= cnt_d;
            a_q                <= a_d;
            d_q                <= d_d;
        end
    end

    // Line contents need no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign spo              = spo_q;
    assign ready            = ready_q;
    assign mem_a            = mem_a_q;
    assign mem_d            = mem_d_q;
    assign mem_rd           = mem_rd_q;
    assign mem_we           = mem_we_q;
    assign mem_burst_en     = mem_burst_en_q;
    assign mem_burst_length = mem_burst_length_q;

endmodule

// File: tb/tb_psram_line_buffer.sv
// Directed bench for psram_line_buffer with a small PSRAM controller model.
// Burst words are data_off + index; writes complete after a short delay.
module tb_psram_line_buffer;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst, rd, we, flush;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   spo;
    logic          ready;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_d;
    logic          mem_rd, mem_we, mem_burst_en;
    logic [7:0]    mem_burst_length;
    logic [31:0]   mem_spo;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    logic          ctl_up;
    logic [31:0]   data_off;
    int            m_mode = 0;
    int            m_gap = 0;
    int            m_idx = 0;
    logic [AW-1:0] cap_rd_a, cap_we_a;
    logic          cap_rd_ben, cap_we_ben;
    logic [7:0]    cap_rd_len, cap_we_len;
    logic [31:0]   cap_we_d;
    int            rd_pulses = 0;
    int            we_pulses = 0;

    always #5 clk = ~clk;

    psram_line_buffer #(.LINE_WORDS(8), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .rd(rd), .we(we), .flush(flush),
        .spo(spo), .ready(ready), .mem_a(mem_a), .mem_d(mem_d),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_burst_en(mem_burst_en),
        .mem_burst_length(mem_burst_length), .mem_spo(mem_spo), .mem_ready(mem_ready)
    );

    // Controller model: ready drops after a request, each word is a one-cycle ready pulse.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_mode = 0; m_gap = 0; mem_ready = ctl_up; mem_spo = 32'd0;
        end else begin
            case (m_mode)
                0: begin
                    if (mem_rd === 1'b1) begin
                        m_mode = 1; m_gap = 0; m_idx = 0; mem_ready = 1'b0;
                        cap_rd_a = mem_a; cap_rd_ben = mem_burst_en; cap_rd_len = mem_burst_length;
                    end else if (mem_we === 1'b1) begin
                        m_mode = 2; m_gap = 0; mem_ready = 1'b0;
                        cap_we_a = mem_a; cap_we_d = mem_d; cap_we_ben = mem_burst_en; cap_we_len = mem_burst_length;
                    end else begin
                        mem_ready = ctl_up;
                    end
                end
                1: begin
                    if (mem_ready) mem_ready = 1'b0;
                    else begin
                        m_gap++;
                        if (m_gap == 2) begin
                            m_gap = 0; mem_spo = data_off + 32'(m_idx); mem_ready = 1'b1; m_idx++;
                            if (m_idx == 8) m_mode = 0;
                        end
                    end
                end
                2: begin
                    m_gap++;
                    if (m_gap == 3) begin mem_ready = 1'b1; m_mode = 0; end
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mem_rd === 1'b1) rd_pulses++;
        if (mem_we === 1'b1) we_pulses++;
    end

    task automatic pulse_rd(input logic [AW-1:0] addr, input logic fl);
        @(negedge clk); a = addr; rd = 1'b1; flush = fl;
        @(negedge clk); rd = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_we(input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clk); a = addr; d = data; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (ready !== 1'b1) begin $display("FAIL %s timeout: ready=%b after %0d cycles, want 1", name, ready, budget); errors++; end
    endtask

    task automatic test_reset();
        ctl_up = 1'b0; rst = 1'b1; rd = 1'b0; we = 1'b0; flush = 1'b0; a = '0; d = '0; data_off = 32'h100;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin $display("FAIL rst_ready got %b want 0", ready); errors++; end
        checks++; if (spo !== 32'd0) begin $display("FAIL rst_spo got %h want 0", spo); errors++; end
        checks++; if ({mem_rd, mem_we, mem_burst_en} !== 3'b000) begin $display("FAIL rst_mem_ctl got %b want 000", {mem_rd, mem_we, mem_burst_en}); errors++; end
        checks++; if (mem_burst_length !== 8'd0 || mem_a !== '0 || mem_d !== 32'd0) begin
            $display("FAIL rst_mem_bus got len=%h a=%h d=%h want 0", mem_burst_length, mem_a, mem_d); errors++; end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin $display("FAIL init_hold got %b want 0", ready); errors++; end
        ctl_up = 1'b1;
        wait_ready("init_ready", 3);
        checks++; if ({mem_rd, mem_we, mem_burst_en} !== 3'b000 || mem_a !== '0) begin
            $display("FAIL init_mem_idle got ctl=%b a=%h want 0", {mem_rd, mem_we, mem_burst_en}, mem_a); errors++; end
    endtask

    task automatic test_read_miss();
        int base = rd_pulses;
        data_off = 32'h100;
        pulse_rd(24'h000104, 1'b0);
        checks++; if (ready !== 1'b0) begin $display("FAIL miss_ready_drop got %b want 0", ready); errors++; end
        wait_ready("miss_fill", 100);
        checks++; if (rd_pulses - base !== 1) begin $display("FAIL miss_rd_pulses got %0d want 1", rd_pulses - base); errors++; end
        checks++; if (cap_rd_a !== 24'h000100) begin $display("FAIL miss_mem_a got %h want 000100", cap_rd_a); errors++; end
        checks++; if (cap_rd_ben !== 1'b1 || cap_rd_len !== 8'd8) begin
            $display("FAIL miss_burst got en=%b len=%0d want 1/8", cap_rd_ben, cap_rd_len); errors++; end
        checks++; if (spo !== 32'h101) begin $display("FAIL miss_spo got %h want 101", spo); errors++; end
        checks++; if (mem_a !== 24'h000100 || mem_burst_en !== 1'b1) begin
            $display("FAIL miss_hold got a=%h en=%b want 000100/1", mem_a, mem_burst_en); errors++; end
    endtask

    task automatic test_read_hit();
        int base = rd_pulses;
        pulse_rd(24'h00011C, 1'b0);
        checks++; if (spo !== 32'h107 || ready !== 1'b1) begin $display("FAIL hit_last got spo=%h ready=%b want 107/1", spo, ready); errors++; end
        pulse_rd(24'h000100, 1'b0);
        checks++; if (spo !== 32'h100 || ready !== 1'b1) begin $display("FAIL hit_first got spo=%h ready=%b want 100/1", spo, ready); errors++; end
        checks++; if (rd_pulses != base) begin $display("FAIL hit_no_burst got %0d want 0", rd_pulses - base); errors++; end
    endtask

    task automatic test_write();
        int wb = we_pulses;
        int rb;
        pulse_we(24'h000108, 32'hDEADBEEF);
        checks++; if (ready !== 1'b0) begin $display("FAIL wr_ready_drop got %b want 0", ready); errors++; end
        wait_ready("wr_done", 50);
        checks++; if (we_pulses - wb !== 1) begin $display("FAIL wr_we_pulses got %0d want 1", we_pulses - wb); errors++; end
        checks++; if (cap_we_a !== 24'h000108 || cap_we_d !== 32'hDEADBEEF) begin
            $display("FAIL wr_bus got a=%h d=%h want 000108/deadbeef", cap_we_a, cap_we_d); errors++; end
        checks++; if (cap_we_ben !== 1'b0 || cap_we_len !== 8'd0) begin
            $display("FAIL wr_burst got en=%b len=%0d want 0/0", cap_we_ben, cap_we_len); errors++; end
        rb = rd_pulses;
        pulse_rd(24'h000108, 1'b0);
        checks++; if (spo !== 32'hDEADBEEF || ready !== 1'b1) begin $display("FAIL wr_hit_update got spo=%h ready=%b want deadbeef/1", spo, ready); errors++; end
        // Same word index, different tag: the buffered line must stay untouched.
        pulse_we(24'h000408, 32'h12345678);
        wait_ready("wr_miss_done", 50);
        checks++; if (cap_we_a !== 24'h000408 || cap_we_d !== 32'h12345678) begin
            $display("FAIL wr_miss_bus got a=%h d=%h want 000408/12345678", cap_we_a, cap_we_d); errors++; end
        pulse_rd(24'h000108, 1'b0);
        checks++; if (spo !== 32'hDEADBEEF) begin $display("FAIL wr_miss_kept got %h want deadbeef", spo); errors++; end
        checks++; if (rd_pulses != rb) begin $display("FAIL wr_no_burst got %0d want 0", rd_pulses - rb); errors++; end
    endtask

    task automatic test_flush();
        int base = rd_pulses;
        data_off = 32'h280;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        pulse_rd(24'h000100, 1'b0);
        wait_ready("flush_only_fill", 100);
        checks++; if (rd_pulses - base !== 1 || spo !== 32'h280) begin
            $display("FAIL flush_only got bursts=%0d spo=%h want 1/280", rd_pulses - base, spo); errors++; end
        base = rd_pulses;
        data_off = 32'h200;
        pulse_rd(24'h000104, 1'b1);
        checks++; if (ready !== 1'b0) begin $display("FAIL flush_rd_miss got ready=%b want 0", ready); errors++; end
        wait_ready("flush_rd_fill", 100);
        checks++; if (rd_pulses - base !== 1 || cap_rd_a !== 24'h000100 || cap_rd_len !== 8'd8) begin
            $display("FAIL flush_rd_burst got n=%0d a=%h len=%0d want 1/000100/8", rd_pulses - base, cap_rd_a, cap_rd_len); errors++; end
        checks++; if (spo !== 32'h201) begin $display("FAIL flush_rd_spo got %h want 201", spo); errors++; end
        pulse_rd(24'h00011C, 1'b0);
        checks++; if (spo !== 32'h207 || rd_pulses - base !== 1) begin
            $display("FAIL flush_refill_hit got spo=%h n=%0d want 207/1", spo, rd_pulses - base); errors++; end
    endtask

    task automatic test_reset_mid_fill();
        int n = 0;
        int base;
        data_off = 32'h300;
        pulse_rd(24'h000208, 1'b0);
        while (!(m_mode == 1 && m_idx == 3) && n < 100) begin @(negedge clk); n++; end
        checks++; if (m_idx != 3) begin $display("FAIL mid_fill_reach got idx=%0d want 3", m_idx); errors++; end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0 || mem_rd !== 1'b0 || mem_a !== '0 || mem_burst_en !== 1'b0) begin
            $display("FAIL mid_rst_state got ready=%b rd=%b a=%h en=%b want 0", ready, mem_rd, mem_a, mem_burst_en); errors++; end
        rst = 1'b0;
        wait_ready("mid_rst_init", 5);
        base = rd_pulses;
        data_off = 32'h500;
        pulse_rd(24'h000104, 1'b0);
        wait_ready("mid_rst_old_line", 100);
        checks++; if (rd_pulses - base !== 1 || spo !== 32'h501) begin
            $display("FAIL mid_rst_invalid got n=%0d spo=%h want 1/501", rd_pulses - base, spo); errors++; end
        base = rd_pulses;
        data_off = 32'h400;
        pulse_rd(24'h00020C, 1'b0);
        wait_ready("mid_rst_refill", 100);
        checks++; if (rd_pulses - base !== 1 || m_idx != 8 || cap_rd_a !== 24'h000200) begin
            $display("FAIL mid_rst_full_burst got n=%0d words=%0d a=%h want 1/8/000200", rd_pulses - base, m_idx, cap_rd_a); errors++; end
        checks++; if (spo !== 32'h403) begin $display("FAIL mid_rst_spo got %h want 403", spo); errors++; end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_flush();
        test_reset_mid_fill();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
